// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - 16-bit ISA opcodes, field layout and immediate range helpers
package isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_PADDSB = 4'h1,
    OP_SUB    = 4'h2,
    OP_AND    = 4'h3,
    OP_NOR    = 4'h4,
    OP_SLL    = 4'h5,
    OP_SRL    = 4'h6,
    OP_SRA    = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_JAL    = 4'hD,
    OP_JR     = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  localparam int REG_W  = 4;
  localparam int COND_W = 3;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  localparam logic [15:0] HLT_WORD = 16'hF000;

  // True when every bit from lsb upward is zero.
  function automatic logic imm_fits_unsigned(input logic [15:0] imm, input int lsb);
    logic [15:0] m;
    m = 16'hFFFF << lsb;
    return (imm & m) == 16'h0000;
  endfunction

  // True when imm[15:msb] are all equal, i.e. imm is a sign extension of imm[msb:0].
  function automatic logic imm_fits_signed(input logic [15:0] imm, input int msb);
    logic [15:0] m;
    m = 16'hFFFF << msb;
    return ((imm & m) == 16'h0000) || ((imm & m) == m);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packer from instruction fields to ISA word
module instr_field_pack
  import isa_pkg::*;
(
  input  logic [3:0]        i_opcode,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [REG_W-1:0]  i_rs,
  input  logic [REG_W-1:0]  i_rt,
  input  logic [COND_W-1:0] i_cond,
  input  logic [15:0]       i_imm,
  output logic [15:0]       o_word,
  output logic              o_range_err
);

  always_comb begin
    o_word      = 16'h0000;
    o_range_err = 1'b0;
    case (i_opcode)
      OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
        o_word = {i_opcode, i_rd, i_rs, i_rt};
      end
      OP_SLL, OP_SRL, OP_SRA: begin
        o_word      = {i_opcode, i_rd, i_rs, i_imm[3:0]};
        o_range_err = ~imm_fits_unsigned(i_imm, 4);
      end
      OP_LW: begin
        o_word      = {i_opcode, i_rd, i_rs, i_imm[3:0]};
        o_range_err = ~imm_fits_signed(i_imm, 3);
      end
      OP_SW: begin
        o_word      = {i_opcode, i_rt, i_rs, i_imm[3:0]};
        o_range_err = ~imm_fits_signed(i_imm, 3);
      end
      OP_LHB: begin
        o_word      = {i_opcode, i_rd, i_imm[7:0]};
        o_range_err = ~imm_fits_unsigned(i_imm, 8);
      end
      OP_LLB: begin
        o_word      = {i_opcode, i_rd, i_imm[7:0]};
        o_range_err = ~imm_fits_signed(i_imm, 7);
      end
      OP_B: begin
        o_word      = {i_opcode, i_cond, i_imm[8:0]};
        o_range_err = ~imm_fits_signed(i_imm, 8);
      end
      OP_JAL: begin
        o_word      = {i_opcode, i_imm[11:0]};
        o_range_err = ~imm_fits_signed(i_imm, 11);
      end
      OP_JR: begin
        o_word = {i_opcode, 4'h0, i_rs, 4'h0};
      end
      default: begin
        o_word = HLT_WORD;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - request-to-word encoder streaming a program image with sequential addresses
module instr_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_opcode,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rs,
  input  logic [3:0]        req_rt,
  input  logic [2:0]        req_cond,
  input  logic [15:0]       req_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [15:0]       r_out_instr;
  logic              r_err;
  logic [ADDR_W-1:0] r_err_addr;

  logic [15:0] w_word;
  logic        w_range_err;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_start_ok;

  instr_field_pack u_pack (
    .i_opcode    (req_opcode),
    .i_rd        (req_rd),
    .i_rs        (req_rs),
    .i_rt        (req_rt),
    .i_cond      (req_cond),
    .i_imm       (req_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err)
  );

  assign w_req_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept    = req_valid && w_req_ready;
  // A restart from DONE waits until the final word has drained.
  assign w_start_ok  = start && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && !r_out_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_instr <= 16'h0000;
      r_err       <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_start_ok) begin
      r_state    <= ST_RUN;
      r_addr     <= base_addr;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_addr  <= r_addr;
      r_out_instr <= w_word;
      r_addr      <= r_addr + 1'b1;
      r_count     <= r_count + 1'b1;
      if (w_range_err && !r_err) begin
        r_err_addr <= r_addr;
      end
      r_err <= r_err | w_range_err;
      if (req_opcode == OP_HLT) begin
        r_state <= ST_DONE;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req_ready  = w_req_ready;
  assign out_valid  = r_out_valid;
  assign out_addr   = r_out_addr;
  assign out_instr  = r_out_instr;
  assign word_count = r_count;
  assign busy       = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE) && !r_out_valid;
  assign err        = r_err;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_opcode = 4'h0;
  logic [3:0]  req_rd = 4'h0;
  logic [3:0]  req_rs = 4'h0;
  logic [3:0]  req_rt = 4'h0;
  logic [2:0]  req_cond = 3'h0;
  logic [15:0] req_imm = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_addr;
  logic [15:0] out_instr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] err_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [15:0] exp_addr = 16'h0000;

  instr_encoder #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_rd     (req_rd),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .req_cond   (req_cond),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_instr  (out_instr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [3:0] rt, input logic [2:0] cond, input logic [15:0] imm);
    req_opcode = op; req_rd = rd; req_rs = rs; req_rt = rt; req_cond = cond; req_imm = imm;
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back requests.
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [2:0] cond, input logic [15:0] imm,
                      input logic [15:0] exp_word);
    int n;
    @(negedge clk);
    set_fields(op, rd, rs, rt, cond, imm);
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    end else begin
      sb.push_back({exp_addr, exp_word});
      exp_addr = exp_addr + 16'd1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] b);
    @(negedge clk);
    req_valid = 1'b0;
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
    exp_addr = b;
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {out_addr, out_instr}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("out_addr", {16'h0, out_addr}, {16'h0, e[31:16]});
          chk("out_instr", {16'h0, out_instr}, {16'h0, e[15:0]});
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("rst_out_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_addr", {16'd0, err_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(1);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd0);

    // Encoding
    do_start(16'h0100);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_req_ready", {31'd0, req_ready}, 32'd1);
    send(4'h0, 4'd1, 4'd2, 4'd3, 3'd0, 16'h0000, 16'h0123);
    send(4'h9, 4'd0, 4'd6, 4'd5, 3'd0, 16'hFFFF, 16'h956F);
    req_valid = 1'b0;
    wait_cycles(2);
    chk("enc_err", {31'd0, err}, 32'd0);
    chk("enc_count", {16'd0, word_count}, 32'd2);

    // Range errors and assorted encodings
    send(4'hB, 4'd2, 4'd0, 4'd0, 3'd0, 16'h0180, 16'hB280);
    req_valid = 1'b0;
    wait_cycles(2);
    chk("llb_err", {31'd0, err}, 32'd1);
    chk("llb_err_addr", {16'd0, err_addr}, 32'h0102);
    send(4'hA, 4'd3, 4'd9, 4'd0, 3'd0, 16'h0100, 16'hA300);
    send(4'h5, 4'd1, 4'd2, 4'd0, 3'd0, 16'h0005, 16'h5125);
    send(4'h8, 4'd4, 4'd5, 4'd0, 3'd0, 16'hFFF8, 16'h8458);
    send(4'hE, 4'd0, 4'd7, 4'd0, 3'd0, 16'h0000, 16'hE070);
    send(4'hD, 4'd0, 4'd0, 4'd0, 3'd0, 16'h07FF, 16'hD7FF);
    req_valid = 1'b0;
    wait_cycles(2);
    chk("lhb_err_addr_kept", {16'd0, err_addr}, 32'h0102);

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    send(4'h4, 4'd1, 4'd1, 4'd1, 3'd0, 16'h0000, 16'h4111);
    set_fields(4'h2, 4'd2, 4'd3, 4'd4, 3'd0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_instr", {16'd0, out_instr}, 32'h4111);
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    send(4'h2, 4'd2, 4'd3, 4'd4, 3'd0, 16'h0000, 16'h2234);
    send(4'h3, 4'd5, 4'd6, 4'd7, 3'd0, 16'h0000, 16'h3567);
    req_valid = 1'b0;
    wait_cycles(2);
    chk("bp_count", {16'd0, word_count}, 32'd11);

    // HLT and restart
    send(4'hC, 4'd0, 4'd0, 4'd0, 3'd3, 16'h01FF, 16'hC7FF);
    send(4'hF, 4'd0, 4'd0, 4'd0, 3'd0, 16'h0000, 16'hF000);
    set_fields(4'h0, 4'd1, 4'd1, 4'd1, 3'd0, 16'h0000);
    req_valid = 1'b1;
    @(negedge clk); #1;
    chk("hlt_pending_done", {31'd0, done}, 32'd0);
    chk("hlt_pending_valid", {31'd0, out_valid}, 32'd1);
    chk("hlt_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); #1;
    chk("hlt_done", {31'd0, done}, 32'd1);
    chk("hlt_drained", {31'd0, out_valid}, 32'd0);
    wait_cycles(3);
    chk("done_no_accept", {31'd0, req_ready}, 32'd0);
    chk("done_count", {16'd0, word_count}, 32'd13);
    req_valid = 1'b0;
    do_start(16'hFFFF);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_count", {16'd0, word_count}, 32'd0);
    chk("restart_err", {31'd0, err}, 32'd0);
    chk("restart_err_addr", {16'd0, err_addr}, 32'd0);

    // Wrap and reset mid-stream
    send(4'h0, 4'd7, 4'd8, 4'd9, 3'd0, 16'h0000, 16'h0789);
    send(4'h7, 4'd1, 4'd1, 4'd0, 3'd0, 16'h000F, 16'h711F);
    out_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("wrap_valid", {31'd0, out_valid}, 32'd1);
    chk("wrap_addr", {16'd0, out_addr}, 32'h0000);
    chk("wrap_instr", {16'd0, out_instr}, 32'h711F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_addr", {16'd0, out_addr}, 32'd0);
    chk("mid_rst_out_instr", {16'd0, out_instr}, 32'd0);
    chk("mid_rst_count", {16'd0, word_count}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_err_addr", {16'd0, err_addr}, 32'd0);
    if (sb.size() > 0) void'(sb.pop_back());
    out_ready = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
